// File: rtl/seq_divider_if.sv
// Operand/result bundle between the CPU control unit (master) and seq_divider (slave).
// unsigned_op exists only when SEQ_DIVIDER_DIVU_EN is defined.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SEQ_DIVIDER_DIVU_EN
  logic             unsigned_op;
`endif
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, a, b,
`ifdef SEQ_DIVIDER_DIVU_EN
    output unsigned_op,
`endif
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, a, b,
`ifdef SEQ_DIVIDER_DIVU_EN
    input  unsigned_op,
`endif
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/seq_divider.sv
// Multicycle restoring divider: hi = remainder (sign of dividend), lo = quotient (truncated).
// Define SEQ_DIVIDER_DIVU_EN to add a per-operation unsigned mode via bus.unsigned_op.
//
// state | meaning
// IDLE  | waiting for start
// PREP  | take magnitudes and result signs of the latched operands
// RUN   | one shift-subtract iteration per cycle, WIDTH cycles
// FIX   | apply signs, load hi/lo
// DONE  | done pulse; a new start is accepted here
// DZERO | div_zero pulse; hi/lo untouched
module seq_divider #(
  parameter int WIDTH = 32
) (
  input logic         clock,
  input logic         reset,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE, S_DZERO
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] babs_q, babs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SEQ_DIVIDER_DIVU_EN
  logic             uns_q, uns_d;
`endif
  logic             uns_now;
  logic             a_neg, b_neg;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      babs_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SEQ_DIVIDER_DIVU_EN
      uns_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      babs_q  <= babs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      cnt_q   <= cnt_d;
`ifdef SEQ_DIVIDER_DIVU_EN
      uns_q   <= uns_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    babs_d  = babs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    cnt_d   = cnt_q;
`ifdef SEQ_DIVIDER_DIVU_EN
    uns_d   = uns_q;
    uns_now = uns_q;
`else
    uns_now = 1'b0;
`endif
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.div_zero = 1'b0;

    a_neg   = !uns_now && a_q[WIDTH-1];
    b_neg   = !uns_now && b_q[WIDTH-1];
    // Remainder needs one extra bit: with unsigned divisors above 2^(WIDTH-1) it can double past WIDTH bits.
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, babs_q};

    case (state_q)
      S_IDLE, S_DONE: begin
        bus.done = (state_q == S_DONE);
        if (bus.start) begin
          if (bus.b == '0) begin
            state_d = S_DZERO;
          end else begin
            a_d     = bus.a;
            b_d     = bus.b;
`ifdef SEQ_DIVIDER_DIVU_EN
            uns_d   = bus.unsigned_op;
`endif
            state_d = S_PREP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DZERO: begin
        bus.div_zero = 1'b1;
        state_d      = S_IDLE;
      end
      S_PREP: begin
        bus.busy = 1'b1;
        qneg_d   = a_neg ^ b_neg;
        rneg_d   = a_neg;
        quo_d    = a_neg ? -a_q : a_q;
        babs_d   = b_neg ? -b_q : b_q;
        rem_d    = '0;
        cnt_d    = '0;
        state_d  = S_RUN;
      end
      S_RUN: begin
        bus.busy = 1'b1;
        if (!trial[WIDTH+1]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        bus.busy = 1'b1;
        lo_d     = qneg_q ? -quo_q : quo_q;
        hi_d     = rneg_q ? -rem_q : rem_q;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: timeline/arithmetic reference model checked every cycle,
// plus directed cases with literal expectations and randomized operations.
module tb_seq_divider;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   c0    = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  seq_divider_if #(.WIDTH(32)) bus ();

  seq_divider #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference arithmetic on 64-bit magnitudes: truncating quotient, remainder takes dividend sign.
  function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y, input logic uns);
    logic sx, sy;
    logic [63:0] ax, ay, q, r;
    sx = !uns && x[31];
    sy = !uns && y[31];
    ax = sx ? 64'h1_0000_0000 - {32'd0, x} : {32'd0, x};
    ay = sy ? 64'h1_0000_0000 - {32'd0, y} : {32'd0, y};
    q  = ax / ay;
    r  = ax % ay;
    if (sx ^ sy) q = -q;
    if (sx) r = -r;
    return {r[31:0], q[31:0]};
  endfunction

  // Timeline model: age = cycle index of the next cycle relative to the accepted start.
  logic        armed = 1'b0;
  logic        e_busy = 1'b0, e_done = 1'b0, e_dz = 1'b0;
  logic [31:0] e_hi = '0, e_lo = '0;
  logic [63:0] pend = '0;
  logic        m_acc, m_uop;
  int          age = 0;

  always @(posedge clock) begin
    if (reset) begin
      age = 0; e_busy = 0; e_done = 0; e_dz = 0; e_hi = '0; e_lo = '0;
      armed = 1'b1;
    end else if (armed) begin
`ifdef SEQ_DIVIDER_DIVU_EN
      m_uop = bus.unsigned_op;
`else
      m_uop = 1'b0;
`endif
      m_acc = bus.start && !e_busy && !e_dz;
      if (m_acc && bus.b != 32'd0) begin
        age  = 1;
        pend = ref_div(bus.a, bus.b, m_uop);
      end else if (age > 0 && age < 36) begin
        age++;
      end
      e_dz   = m_acc && (bus.b == 32'd0);
      e_busy = (age >= 1) && (age <= 34);
      e_done = (age == 35);
      if (age == 35) {e_hi, e_lo} = pend;
    end
  end

  always @(negedge clock) begin
    if (armed) begin
      chk("busy",     {31'd0, bus.busy},     {31'd0, e_busy});
      chk("done",     {31'd0, bus.done},     {31'd0, e_done});
      chk("div_zero", {31'd0, bus.div_zero}, {31'd0, e_dz});
      chk("hi",       bus.hi, e_hi);
      chk("lo",       bus.lo, e_lo);
      chk("done_and_div_zero", {31'd0, bus.done & bus.div_zero}, 32'd0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_uop(input logic uo);
`ifdef SEQ_DIVIDER_DIVU_EN
    bus.unsigned_op = uo;
`else
    if (uo) $display("note: unsigned_op ignored in signed build");
`endif
  endtask

  task automatic wait_flag(input bit dz, input int limit, output int off, output int busy_n);
    off = -1;
    busy_n = 0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clock);
      if (bus.busy) busy_n++;
      if (dz ? bus.div_zero : bus.done) begin
        off = cyc - c0;
        return;
      end
    end
  endtask

  task automatic do_op(input string nm, input logic [31:0] aa, input logic [31:0] bb, input logic uo,
                       input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int off, bn;
    step(1);
    c0 = cyc;
    bus.start = 1'b1; bus.a = aa; bus.b = bb; set_uop(uo);
    step(1);
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; set_uop(~uo);
    wait_flag(1'b0, 45, off, bn);
    chk({nm, "_done_cycle"}, off, 32'd35);
    chk({nm, "_busy_cycles"}, bn, 32'd34);
    chk({nm, "_lo"}, bus.lo, exp_lo);
    chk({nm, "_hi"}, bus.hi, exp_hi);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 20);
      5: return 32'd0 - $urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int off, bn, dones;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; set_uop(1'b0);
    step(3);
    reset = 1'b0;
    @(negedge clock);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);

    do_op("pos",  32'd7,          32'd2,          1'b0, 32'd3,          32'd1);
    do_op("nega", 32'hFFFF_FFF9,  32'd2,          1'b0, 32'hFFFF_FFFD,  32'hFFFF_FFFF);
    do_op("negb", 32'd7,          32'hFFFF_FFFE,  1'b0, 32'hFFFF_FFFD,  32'd1);
    do_op("min",  32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000,  32'd0);
    do_op("pos2", 32'd7,          32'd2,          1'b0, 32'd3,          32'd1);

    // Divide by zero leaves the previous 3/1 in place.
    step(1);
    c0 = cyc;
    bus.start = 1'b1; bus.a = 32'd5; bus.b = 32'd0;
    step(1);
    bus.start = 1'b0;
    wait_flag(1'b1, 5, off, bn);
    chk("dz_cycle", off, 32'd1);
    chk("dz_done", {31'd0, bus.done}, 32'd0);
    chk("dz_busy", {31'd0, bus.busy}, 32'd0);
    chk("dz_hi", bus.hi, 32'd1);
    chk("dz_lo", bus.lo, 32'd3);

    // Start during busy is ignored; reset at cycle 20 aborts.
    step(1);
    c0 = cyc;
    bus.start = 1'b1; bus.a = 32'd100; bus.b = 32'd7;
    step(1);
    bus.start = 1'b0;
    step(9);
    bus.start = 1'b1; bus.a = 32'd50; bus.b = 32'd5;
    step(1);
    bus.start = 1'b0;
    step(9);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    @(negedge clock);
    chk("abort_cycle", cyc - c0, 32'd21);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (bus.done || bus.busy) dones++;
    end
    chk("abort_no_done", dones, 32'd0);

    // Back-to-back: start held through the first DONE cycle.
    step(1);
    c0 = cyc;
    bus.start = 1'b1; bus.a = 32'd9; bus.b = 32'd3;
    wait_flag(1'b0, 45, off, bn);
    chk("b2b_first_done", off, 32'd35);
    step(1);
    bus.start = 1'b0;
    wait_flag(1'b0, 45, off, bn);
    chk("b2b_second_done", off, 32'd70);
    chk("b2b_lo", bus.lo, 32'd3);
    chk("b2b_hi", bus.hi, 32'd0);

`ifdef SEQ_DIVIDER_DIVU_EN
    do_op("divu",    32'hFFFF_FFFF, 32'd2, 1'b1, 32'h7FFF_FFFF, 32'd1);
    do_op("div_neg", 32'hFFFF_FFFF, 32'd2, 1'b0, 32'd0,         32'hFFFF_FFFF);
    do_op("divu_big", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'hFFFF_FFFE);
`endif

    for (int i = 0; i < 160; i++) begin
      bus.a = rnd_operand();
      bus.b = rnd_operand();
      set_uop(1'($urandom_range(0, 1)));
      bus.start = 1'b1;
      step($urandom_range(1, 3));
      bus.start = 1'b0;
      bus.a = $urandom;
      bus.b = $urandom;
      if ($urandom_range(0, 24) == 0) begin
        step($urandom_range(1, 30));
        reset = 1'b1;
        step(1);
        reset = 1'b0;
      end
      step($urandom_range(0, 40));
    end
    step(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
